// File: rtl/uart_rx_if.sv
// System-side bundle of the UART receiver: frame configuration in,
// received word and its one-cycle status strobes out.
interface uart_rx_if #(parameter int width = 8);
  logic [5:0]       Prescale;
  logic             Parity_EN;
  logic             Parity_type;
  logic [width-1:0] P_DATA;
  logic             Data_valid;
  logic             Parity_Error;
  logic             Stop_Error;

  modport master (
    input  Prescale, Parity_EN, Parity_type,
    output P_DATA, Data_valid, Parity_Error, Stop_Error
  );

  modport slave (
    output Prescale, Parity_EN, Parity_type,
    input  P_DATA, Data_valid, Parity_Error, Stop_Error
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing, 3-sample majority vote
// per bit around the bit centre, one-cycle valid/error strobes.
module uart_rx #(
  parameter int width = 8
) (
  input  logic      CLK,
  input  logic      Reset,
  input  logic      RX_IN,
  uart_rx_if.master bus
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic             rx_meta;
  logic             rx_s;
  logic [2:0]       state;
  logic [5:0]       presc_q;
  logic             pen_q;
  logic             ptype_q;
  logic [5:0]       edge_cnt;
  logic [CW-1:0]    bit_cnt;
  logic [width-1:0] shift;
  logic             s0;
  logic             s1;
  logic             par_bad;

  logic [5:0] half;
  logic       edge_lo;
  logic       edge_mid;
  logic       edge_dec;
  logic       edge_last;
  logic       maj;
  logic       exp_par;

  // Sample points sit on the three edges around the centre of each bit;
  // the vote uses the live rx_s as its third sample.
  assign half      = {1'b0, presc_q[5:1]};
  assign edge_lo   = (edge_cnt == half - 6'd1);
  assign edge_mid  = (edge_cnt == half);
  assign edge_dec  = (edge_cnt == half + 6'd1);
  assign edge_last = (edge_cnt == presc_q - 6'd1);
  assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign exp_par   = ptype_q ? ~(^shift) : (^shift);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rx_meta          <= 1'b1;
      rx_s             <= 1'b1;
      state            <= IDLE;
      presc_q          <= '0;
      pen_q            <= 1'b0;
      ptype_q          <= 1'b0;
      edge_cnt         <= '0;
      bit_cnt          <= '0;
      shift            <= '0;
      s0               <= 1'b0;
      s1               <= 1'b0;
      par_bad          <= 1'b0;
      bus.P_DATA       <= '0;
      bus.Data_valid   <= 1'b0;
      bus.Parity_Error <= 1'b0;
      bus.Stop_Error   <= 1'b0;
    end else begin
      rx_meta          <= RX_IN;
      rx_s             <= rx_meta;
      bus.Data_valid   <= 1'b0;
      bus.Parity_Error <= 1'b0;
      bus.Stop_Error   <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= edge_last ? 6'd0 : edge_cnt + 6'd1;
        if (edge_lo)
          s0 <= rx_s;
        if (edge_mid)
          s1 <= rx_s;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            presc_q  <= bus.Prescale;
            pen_q    <= bus.Parity_EN;
            ptype_q  <= bus.Parity_type;
          end
        end

        START: begin
          if (edge_dec && maj) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (edge_last) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (edge_dec)
            shift <= {maj, shift[width-1:1]};
          if (edge_last) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= pen_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end

        PARITY: begin
          if (edge_dec)
            par_bad <= (maj != exp_par);
          if (edge_last)
            state <= STOP;
        end

        // Leave at the stop-bit decision so a back-to-back start edge is seen.
        STOP: begin
          if (edge_dec) begin
            state            <= IDLE;
            edge_cnt         <= '0;
            bus.Stop_Error   <= ~maj;
            bus.Parity_Error <= par_bad;
            if (maj && !par_bad) begin
              bus.Data_valid <= 1'b1;
              bus.P_DATA     <= shift;
            end
          end
        end

        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for glitches, back-to-back frames and mid-frame reset.
module tb_uart_rx;

  logic CLK;
  logic Reset;
  logic RX_IN;

  uart_rx_if #(.width(8)) ifc ();

  uart_rx #(.width(8)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .RX_IN (RX_IN),
    .bus   (ifc.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] presc;
    logic       pen;
    logic       ptype;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       scramble;
    int         exp_valid;
    int         exp_perr;
    int         exp_serr;
    logic [7:0] exp_pdata;
  } vec_t;

  vec_t vecs[7];

  int assertions = 0;
  int failures   = 0;

  int valid_cnt = 0;
  int perr_cnt  = 0;
  int serr_cnt  = 0;
  int long_cnt  = 0;
  logic [7:0] data_q[$];
  logic prev_strobe = 1'b0;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (ifc.Data_valid) begin
      valid_cnt++;
      data_q.push_back(ifc.P_DATA);
    end
    if (ifc.Parity_Error)
      perr_cnt++;
    if (ifc.Stop_Error)
      serr_cnt++;
    if (prev_strobe && (ifc.Data_valid || ifc.Parity_Error || ifc.Stop_Error))
      long_cnt++;
    prev_strobe = ifc.Data_valid | ifc.Parity_Error | ifc.Stop_Error;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      RX_IN = 1'b1;
    end
  endtask

  // Drive one frame, P cycles per bit, optionally inverting one cycle per bit.
  task automatic send_frame(input logic [5:0] p, input logic [7:0] d, input logic pen,
                            input logic pbit, input logic stop, input int glitch_idx,
                            input logic scramble);
    logic [10:0] fr;
    int nb;
    fr = '0;
    fr[8:1] = d;
    nb = 9;
    if (pen) begin
      fr[9] = pbit;
      nb = 10;
    end
    fr[nb] = stop;
    nb++;
    for (int b = 0; b < nb; b++) begin
      if (scramble && b == 1) begin
        ifc.Prescale    = 6'd32;
        ifc.Parity_EN   = ~ifc.Parity_EN;
        ifc.Parity_type = ~ifc.Parity_type;
      end
      for (int c = 0; c < int'(p); c++) begin
        @(posedge CLK);
        #1;
        RX_IN = (c == glitch_idx) ? ~fr[b] : fr[b];
      end
    end
  endtask

  task automatic applyStimulus(input int idx);
    int v0, p0, s0;
    string tag;
    vec_t v;
    v = vecs[idx];
    ifc.Prescale    = v.presc;
    ifc.Parity_EN   = v.pen;
    ifc.Parity_type = v.ptype;
    v0 = valid_cnt;
    p0 = perr_cnt;
    s0 = serr_cnt;
    send_frame(v.presc, v.data, v.pen, v.pbit, v.stop, -1, v.scramble);
    idle(3 * int'(v.presc) + 10);
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, " valid"}, valid_cnt - v0, v.exp_valid);
    checkOutput({tag, " parity_err"}, perr_cnt - p0, v.exp_perr);
    checkOutput({tag, " stop_err"}, serr_cnt - s0, v.exp_serr);
    checkOutput({tag, " P_DATA"}, int'(ifc.P_DATA), int'(v.exp_pdata));
  endtask

  initial begin
    int v0, p0, s0, q0;

    //            presc  pen   ptype data    pbit  stop  scr   val perr serr pdata
    vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
    vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'h3C};
    vecs[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 0, 1, 0, 8'h3C};
    vecs[3] = '{6'd8,  1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'h01};
    vecs[4] = '{6'd8,  1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 0, 0, 1, 8'h01};
    vecs[5] = '{6'd32, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 0, 1, 1, 8'h01};
    vecs[6] = '{6'd8,  1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'hC3};

    RX_IN           = 1'b1;
    Reset           = 1'b0;
    ifc.Prescale    = 6'd8;
    ifc.Parity_EN   = 1'b0;
    ifc.Parity_type = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset P_DATA", int'(ifc.P_DATA), 0);
    checkOutput("reset Data_valid", int'(ifc.Data_valid), 0);
    checkOutput("reset Parity_Error", int'(ifc.Parity_Error), 0);
    checkOutput("reset Stop_Error", int'(ifc.Stop_Error), 0);
    #1;
    Reset = 1'b1;
    idle(10);

    for (int i = 0; i < 7; i++)
      applyStimulus(i);

    // Short low pulse on an idle line is a false start.
    ifc.Prescale  = 6'd8;
    ifc.Parity_EN = 1'b0;
    v0 = valid_cnt; p0 = perr_cnt; s0 = serr_cnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      RX_IN = 1'b0;
    end
    idle(40);
    checkOutput("glitch strobes", (valid_cnt - v0) + (perr_cnt - p0) + (serr_cnt - s0), 0);
    send_frame(6'd8, 8'h7E, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(40);
    checkOutput("after glitch valid", valid_cnt - v0, 1);
    checkOutput("after glitch P_DATA", int'(ifc.P_DATA), 8'h7E);

    // Back-to-back frames with a one-cycle glitch on each centre sample.
    ifc.Prescale  = 6'd32;
    ifc.Parity_EN = 1'b0;
    v0 = valid_cnt; p0 = perr_cnt; s0 = serr_cnt; q0 = data_q.size();
    send_frame(6'd32, 8'h12, 1'b0, 1'b0, 1'b1, 17, 1'b0);
    send_frame(6'd32, 8'h34, 1'b0, 1'b0, 1'b1, 17, 1'b0);
    idle(120);
    checkOutput("b2b valid count", valid_cnt - v0, 2);
    checkOutput("b2b errors", (perr_cnt - p0) + (serr_cnt - s0), 0);
    if (data_q.size() >= q0 + 2) begin
      checkOutput("b2b first word", int'(data_q[q0]), 8'h12);
      checkOutput("b2b second word", int'(data_q[q0 + 1]), 8'h34);
    end else begin
      checkOutput("b2b words captured", data_q.size() - q0, 2);
    end

    // Reset in the middle of data bit 4 of 0xFF.
    ifc.Prescale  = 6'd16;
    ifc.Parity_EN = 1'b0;
    v0 = valid_cnt; p0 = perr_cnt; s0 = serr_cnt;
    for (int c = 0; c < 16; c++) begin
      @(posedge CLK);
      #1;
      RX_IN = 1'b0;
    end
    for (int c = 0; c < 4 * 16 + 8; c++) begin
      @(posedge CLK);
      #1;
      RX_IN = 1'b1;
    end
    Reset = 1'b0;
    repeat (4) @(negedge CLK);
    checkOutput("mid-frame reset P_DATA", int'(ifc.P_DATA), 0);
    #1;
    Reset = 1'b1;
    idle(60);
    checkOutput("aborted frame strobes", (valid_cnt - v0) + (perr_cnt - p0) + (serr_cnt - s0), 0);
    send_frame(6'd16, 8'h0F, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(60);
    checkOutput("post-reset valid", valid_cnt - v0, 1);
    checkOutput("post-reset P_DATA", int'(ifc.P_DATA), 8'h0F);

    checkOutput("strobe width", long_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver and the counterpart of the team's UART transmitter, on the same link format: 1 start bit (0), `width` data bits LSB first, optional parity bit, 1 stop bit (1). Line idles high.
- Oversamples the serial input at `Prescale` CLK cycles per bit and detects the start bit. Uses a 3-sample majority vote per bit and checks parity and stop.
- Presents the deserialized word with a one-cycle valid strobe.
- Sits between the pad/loopback line and the system control block.

Parameters:
- width, 8, number of data bits per frame

Ports:
- CLK  input  1  system clock; runs at Prescale × bit rate
- Reset  input  1  asynchronous, active-low reset
- RX_IN  input  1  serial line, asynchronous to CLK
- Prescale  input  6  oversampling ratio; legal values 8, 16, 32
- Parity_EN  input  1  1 = frame carries a parity bit
- Parity_type  input  1  0 = even parity, 1 = odd parity (same encoding as the transmitter)
- P_DATA  output  width  last correctly received word
- Data_valid  output  1  one-cycle strobe: P_DATA updated with a good frame
- Parity_Error  output  1  one-cycle strobe: parity mismatch in the frame just ended
- Stop_Error  output  1  one-cycle strobe: stop bit sampled as 0

Behaviour:
- Reset (async, active-low): P_DATA=0, Data_valid=0, Parity_Error=0, Stop_Error=0, FSM=IDLE, all counters 0, synchronizer flops=1.
- RX_IN passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- Prescale, Parity_EN and Parity_type are latched when a frame starts (IDLE->START). Changes mid-frame have no effect. Non-legal Prescale values give undefined behaviour.
- Edge counter `edge_cnt` counts 0..P-1 within each bit, where P is the latched Prescale. `bit_cnt` counts data bits 0..width-1.
- Sampling: rx_s is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three, decided in the cycle with edge_cnt = P/2+1.
- IDLE: when rx_s=0, go to START with edge_cnt=0; that cycle is edge 0 of the start bit.
- START: if the majority is 1, treat it as a glitch and return to IDLE with no strobes. Otherwise continue to edge P-1, then go to DATA.
- DATA: shift each majority bit into the shift register LSB first. After bit width-1 reaches edge P-1, go to PARITY if Parity_EN=1, else go to STOP.
- PARITY: expected bit = Parity_type ? ~^shift : ^shift. Store mismatch in the internal flag `par_bad`. At edge P-1, go to STOP.
- STOP: at the majority decision (edge P/2+1), go to IDLE immediately rather than waiting for the bit end, so a back-to-back start bit is not missed. In the next cycle the strobes are registered as follows:
  - stop majority = 0: Stop_Error=1.
  - par_bad=1: Parity_Error=1. Both errors may assert in the same cycle.
  - neither error: Data_valid=1 and P_DATA <= shift.
  - any error: P_DATA holds its previous value.
- All strobes are high for exactly one CLK and are otherwise 0.
- Back-to-back frames: a falling edge of rx_s arriving in IDLE the cycle after the STOP decision must be accepted.
- RX_IN stuck low after a frame: if the stop bit is 0, flag Stop_Error. Then re-enter START on the next cycle in IDLE with rx_s=0. Frames continue to be evaluated normally.
- Reset asserted mid-frame: all state aborts immediately to reset values. No strobe is produced for the partial frame.
- Latency: Data_valid rises 2 (sync) + 1 (register) cycles after the stop-bit centre sample at edge P/2+1.

Test Plan:
- Prescale=8, Parity_EN=0: send 0xA5 -> Data_valid pulses once for 1 cycle, P_DATA=0xA5, no error strobes.
- Prescale=16, Parity_EN=1, Parity_type=0: send 0x3C with parity 0 -> Data_valid, P_DATA=0x3C. Resend with parity 1 -> Parity_Error pulse, no Data_valid, P_DATA stays 0x3C.
- Prescale=8, Parity_EN=1, Parity_type=1: send 0x01 with parity 0 -> Data_valid, P_DATA=0x01. Then send 0x55 with stop bit 0 -> Stop_Error pulse only, P_DATA stays 0x01.
- Prescale=8: drive RX_IN low for 3 CLK, then high -> FSM returns to IDLE, no strobes. Then send 0x7E -> P_DATA=0x7E.
- Prescale=32: send frames 0x12 and 0x34 back-to-back with no idle between them -> two Data_valid pulses with P_DATA=0x12 then 0x34. A single-cycle inverted glitch at each bit's centre sample still yields correct data.
- Prescale=16: assert Reset during data bit 4 of frame 0xFF, release, then send 0x0F -> no strobe for the aborted frame, then Data_valid with P_DATA=0x0F.
